// File: rtl/semafor_ctrl.sv
// Pedestrian-actuated crossing controller: latched request, minimum car green, all-red clearance.
// Optional NIGHT_MODE_EN adds a `night` input and a flashing-yellow NIGHT state.
module semafor_ctrl #(
  parameter int CNT_W       = 8,
  parameter int T_MIN_GREEN = 5,
  parameter int T_YELLOW    = 3,
  parameter int T_ALLRED    = 1,
  parameter int T_PED       = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       ped_req,
`ifdef NIGHT_MODE_EN
  input  logic       night,
`endif
  output logic       R,
  output logic       Y,
  output logic       G,
  output logic       R_P,
  output logic       G_P,
  output logic       ped_wait,
  output logic [2:0] phase
);

  typedef enum logic [2:0] {
    S_GREEN   = 3'd0,
    S_YELLOW  = 3'd1,
    S_ALLRED1 = 3'd2,
    S_PED     = 3'd3,
    S_ALLRED2 = 3'd4,
    S_NIGHT   = 3'd5
  } state_t;

  localparam logic [CNT_W-1:0] MG_L  = CNT_W'(T_MIN_GREEN - 1);
  localparam logic [CNT_W-1:0] YEL_L = CNT_W'(T_YELLOW - 1);
  localparam logic [CNT_W-1:0] AR_L  = CNT_W'(T_ALLRED - 1);
  localparam logic [CNT_W-1:0] PED_L = CNT_W'(T_PED - 1);

  state_t           state, nxt;
  logic [CNT_W-1:0] cnt;
  logic             req_ok;

  // Requests are only latched in car-side states; PED and NIGHT ignore them.
  assign req_ok = (state == S_GREEN) || (state == S_YELLOW) ||
                  (state == S_ALLRED1) || (state == S_ALLRED2);

  always_comb begin
    nxt = state;
    case (state)
      S_GREEN:
        if (tick) begin
`ifdef NIGHT_MODE_EN
          if (night) nxt = S_NIGHT; else
`endif
          if (ped_wait && cnt == MG_L) nxt = S_YELLOW;
        end
      S_YELLOW:  if (tick && cnt == YEL_L) nxt = S_ALLRED1;
      S_ALLRED1: if (tick && cnt == AR_L)  nxt = S_PED;
      S_PED:     if (tick && cnt == PED_L) nxt = S_ALLRED2;
      S_ALLRED2: if (tick && cnt == AR_L)  nxt = S_GREEN;
`ifdef NIGHT_MODE_EN
      S_NIGHT:   if (tick && !night)       nxt = S_GREEN;
`endif
      default:   nxt = S_GREEN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_GREEN;
      cnt      <= '0;
      ped_wait <= 1'b0;
      R        <= 1'b0;
      Y        <= 1'b0;
      G        <= 1'b1;
      R_P      <= 1'b1;
      G_P      <= 1'b0;
      phase    <= 3'd0;
    end else begin
      state <= nxt;
      phase <= nxt;

      // Green counter saturates so a late request is served on the very next tick.
      if (nxt != state)
        cnt <= '0;
      else if (tick && !(state == S_GREEN && cnt == MG_L))
        cnt <= cnt + 1'b1;

      if (nxt == S_PED && state != S_PED)
        ped_wait <= 1'b0;
`ifdef NIGHT_MODE_EN
      else if (nxt == S_NIGHT)
        ped_wait <= 1'b0;
`endif
      else if (ped_req && req_ok)
        ped_wait <= 1'b1;

      // Lamps decoded from the next state so they line up with the registered phase.
      R   <= (nxt == S_ALLRED1) || (nxt == S_PED) || (nxt == S_ALLRED2);
      G   <= (nxt == S_GREEN);
      R_P <= (nxt == S_GREEN) || (nxt == S_YELLOW) ||
             (nxt == S_ALLRED1) || (nxt == S_ALLRED2);
      G_P <= (nxt == S_PED);
`ifdef NIGHT_MODE_EN
      if (nxt == S_NIGHT)
        Y <= (state != S_NIGHT) ? 1'b1 : (tick ? ~Y : Y);
      else
        Y <= (nxt == S_YELLOW);
`else
      Y <= (nxt == S_YELLOW);
`endif
    end
  end

endmodule

// File: tb/tb_semafor_ctrl.sv
// Randomised bench for semafor_ctrl (default build) against a phase/elapsed-tick reference model.
module tb_semafor_ctrl;
  localparam int T_MIN_GREEN = 5;
  localparam int T_YELLOW    = 3;
  localparam int T_ALLRED    = 1;
  localparam int T_PED       = 8;

  logic       clk = 1'b0;
  logic       rst, tick, ped_req;
  logic       R, Y, G, R_P, G_P, ped_wait;
  logic [2:0] phase;
`ifdef NIGHT_MODE_EN
  logic       night = 1'b0;
`endif

  int n_chk = 0;
  int n_err = 0;

  // Reference model: phase index, ticks elapsed in the phase, latched request.
  int m_ph  = 0;
  int m_el  = 0;
  bit m_wait = 1'b0;
  int dur [5] = '{0, T_YELLOW, T_ALLRED, T_PED, T_ALLRED};

  semafor_ctrl #(.CNT_W(8), .T_MIN_GREEN(T_MIN_GREEN), .T_YELLOW(T_YELLOW),
                 .T_ALLRED(T_ALLRED), .T_PED(T_PED)) dut (
    .clk(clk), .rst(rst), .tick(tick), .ped_req(ped_req),
`ifdef NIGHT_MODE_EN
    .night(night),
`endif
    .R(R), .Y(Y), .G(G), .R_P(R_P), .G_P(G_P),
    .ped_wait(ped_wait), .phase(phase)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic int lamps_of(input int ph);
    // {R,Y,G,R_P,G_P}
    case (ph)
      0:       return 5'b00110;
      1:       return 5'b01010;
      2, 4:    return 5'b10010;
      3:       return 5'b10001;
      default: return 5'b00000;
    endcase
  endfunction

  function automatic void model_step(input bit r, input bit t, input bit q);
    int nph;
    if (r) begin
      m_ph = 0; m_el = 0; m_wait = 1'b0;
      return;
    end
    nph = m_ph;
    if (t) begin
      if (m_ph == 0) begin
        // Serve a request once at least T_MIN_GREEN ticks of green have elapsed.
        if (m_wait && m_el + 1 >= T_MIN_GREEN) nph = 1;
      end else if (m_el + 1 == dur[m_ph]) begin
        nph = (m_ph + 1) % 5;
      end
    end
    if (nph == 3 && m_ph != 3) m_wait = 1'b0;
    else if (q && m_ph != 3)   m_wait = 1'b1;
    if (nph != m_ph) m_el = 0;
    else if (t)      m_el++;
    m_ph = nph;
  endfunction

  task automatic cycle(input bit r, input bit t, input bit q);
    @(negedge clk);
    rst = r; tick = t; ped_req = q;
    model_step(r, t, q);
    @(posedge clk);
    #1;
    chk("phase", int'(phase), m_ph);
    chk("lamps", int'({R, Y, G, R_P, G_P}), lamps_of(m_ph));
    chk("ped_wait", int'(ped_wait), int'(m_wait));
  endtask

  initial begin
    int tick_pct, req_pct, steps;
    rst = 1'b1; tick = 1'b0; ped_req = 1'b0;
    cycle(1, 0, 0);
    cycle(1, 1, 1);

    // Idle: 20 ticks without requests keep car green.
    for (int i = 0; i < 40; i++) cycle(0, i[0], 0);

    // Segments with varied tick and request densities.
    for (int seg = 0; seg < 24; seg++) begin
      tick_pct = $urandom_range(10, 100);
      req_pct  = (seg % 3 == 0) ? 0 : ((seg % 3 == 1) ? $urandom_range(1, 5) : $urandom_range(30, 100));
      for (int i = 0; i < 600; i++)
        cycle(($urandom_range(0, 999) == 0), ($urandom_range(1, 100) <= tick_pct),
              ($urandom_range(1, 100) <= req_pct));
    end

    // Reset in the middle of the pedestrian phase aborts straight to green.
    cycle(0, 0, 1);
    steps = 0;
    while (!(m_ph == 3 && m_el == 3) && steps < 400) begin
      cycle(0, 1, 0);
      steps++;
    end
    chk("reach_ped", m_ph, 3);
    cycle(1, 1, 1);
    chk("rst_mid_ped_gp", int'(G_P), 0);
    for (int i = 0; i < 12; i++) cycle(0, 1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end

endmodule
